axi_lite_master_bridge: RTL and testbench
=========================================

Name: axi_lite_master_bridge

Overview:
- AXI4-Lite initiator that converts a simple valid/ready command stream into single AXI-Lite read or write transactions.
- Returns one response per command.
- Drives the S00_AXI slave port of the CORDIC accelerator toplevel from on-chip test/sequencer logic, e.g. a register-programming FSM or a bench-replacement driver.
- One outstanding transaction at a time.

Parameters:
- C_M00_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32 for this block.
- C_M00_AXI_ADDR_WIDTH, 5, AXI byte-address width; matches the accelerator slave.
- TIMEOUT_CYCLES, 256, maximum wait for BVALID/RVALID after the address phase completes; 0 disables the timeout.

Ports:
- m00_axi_aclk  in  1  clock
- m00_axi_areset  in  1  reset; synchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP copy; 2'b00 on timeout
- rsp_timeout  out  1  transaction abandoned on timeout
- m00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master directions and widths. awprot and arprot are tied to 3'b000.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. Every valid/ready output is 0 except cmd_ready=1. Registered address/data outputs, rsp_rdata, rsp_resp, rsp_timeout and the timeout counter are 0.
- All AXI and rsp outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr/wdata/wstrb.
  - Write: next cycle awvalid=1 and wvalid=1; go to WR_ADDR.
  - Read: next cycle arvalid=1; go to RD_ADDR.
- WR_ADDR: awvalid and wvalid drop independently on their own handshake; they may complete in the same cycle or in either order.
  - Once both have completed, assert bready and go to WR_RESP.
  - Valids never drop before their handshake (AXI rule); this wait is unbounded.
- WR_RESP: bready=1. On bvalid, capture bresp, rsp_rdata=0, drop bready, go to RESP.
- RD_ADDR: arvalid held until arready. The cycle after the handshake: rready=1, go to RD_DATA.
- RD_DATA: on rvalid, capture rdata/rresp, drop rready, go to RESP.
- Timeout:
  - Counter clears on entry to WR_RESP/RD_DATA and increments each cycle spent in them.
  - When the counter reaches TIMEOUT_CYCLES with no bvalid/rvalid: drop bready/rready, set rsp_timeout=1, rsp_resp=0, rsp_rdata=0, go to RESP.
  - bvalid/rvalid in the same cycle as expiry counts as success; no timeout.
- RESP: rsp_valid=1, with payload stable until rsp_ready. On handshake, rsp_valid=0 and cmd_ready=1 the next cycle (IDLE); rsp_timeout clears.
- Latency, zero-wait slave: command accept at cycle N, AW/W valid N+1, bready N+2, rsp_valid N+4 with bvalid at N+3. Read path is identical via AR/R.
- cmd_ready is 0 in every non-IDLE state; back-to-back commands are separated by at least one IDLE cycle.
- Reset mid-transaction: all valids/readies drop in the next cycle regardless of pending handshakes. System reset must also reset the slave.

Test Plan:
- Write 0xDEADBEEF, wstrb 4'hF, addr 5'h04; slave awready=wready=1, bvalid a cycle later with bresp=00 -> AW/W valid one cycle after accept; rsp_valid with rsp_resp=00, rsp_rdata=0, rsp_timeout=0; cmd_ready returns after rsp_ready.
- Write, slave holds wready low 5 cycles after awready -> awvalid drops on its handshake; wvalid stays high until wready; bready asserts only after both; single response.
- Read addr 5'h08, slave returns rdata=0x12345678, rresp=00 after 3 cycles -> rsp_rdata=0x12345678, rsp_resp=00; rready deasserts the cycle after the rvalid handshake.
- Read, slave returns rresp=2'b10 with rsp_ready held low 4 cycles -> rsp_valid and payload stable for those 4 cycles, rsp_resp=10; no new AXI activity.
- TIMEOUT_CYCLES=8, write with bvalid never asserted -> bready high exactly 8 cycles then low; rsp_timeout=1, rsp_resp=00; next command proceeds normally.
- Reset asserted while arvalid pending -> next cycle arvalid=0, cmd_ready=1, rsp_valid=0; a following read completes correctly.

Source files
------------

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
// Shared by the command bridge and whatever slave it drives.
interface axi_lite_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Turns a valid/ready command stream into single AXI4-Lite transactions,
// one outstanding at a time, with a bounded wait on the response channel.
module axi_lite_master_bridge #(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES       = 256
) (
    input  logic                              m00_axi_aclk,
    input  logic                              m00_axi_areset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    axi_lite_if.master                        m00_axi
);
    localparam int DW = C_M00_AXI_DATA_WIDTH;
    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP
    } state_t;

    state_t          state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            expired;
    logic            aw_done, w_done;

    assign cnt_inc = cnt_q + CW'(1);
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO);
    assign aw_done = !awvalid_q || m00_axi.awready;
    assign w_done  = !wvalid_q || m00_axi.wready;

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                // AW and W retire independently, in either order.
                if (awvalid_q && m00_axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && m00_axi.wready) wvalid_d = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m00_axi.bvalid) begin
                    bready_d      = 1'b0;
                    rsp_resp_d    = m00_axi.bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (expired) begin
                    bready_d      = 1'b0;
                    rsp_resp_d    = 2'b00;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RD_ADDR: begin
                if (m00_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m00_axi.rvalid) begin
                    rready_d      = 1'b0;
                    rsp_resp_d    = m00_axi.rresp;
                    rsp_rdata_d   = m00_axi.rdata;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (expired) begin
                    rready_d      = 1'b0;
                    rsp_resp_d    = 2'b00;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    cmd_ready_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_resp        = rsp_resp_q;
    assign rsp_timeout     = rsp_timeout_q;
    assign m00_axi.awaddr  = addr_q;
    assign m00_axi.awprot  = 3'b000;
    assign m00_axi.awvalid = awvalid_q;
    assign m00_axi.wdata   = wdata_q;
    assign m00_axi.wstrb   = wstrb_q;
    assign m00_axi.wvalid  = wvalid_q;
    assign m00_axi.bready  = bready_q;
    assign m00_axi.araddr  = addr_q;
    assign m00_axi.arprot  = 3'b000;
    assign m00_axi.arvalid = arvalid_q;
    assign m00_axi.rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for the AXI-Lite command bridge: scripted slave responses,
// expected responses queued at command time and compared on delivery.
module tb_axi_lite_master_bridge;
    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    axi_lite_if #(.ADDR_W(5), .DATA_W(32)) axi ();

    axi_lite_master_bridge #(
        .C_M00_AXI_DATA_WIDTH(32),
        .C_M00_AXI_ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .m00_axi_aclk(clk),
        .m00_axi_areset(areset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .m00_axi(axi.master)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmd_ready) $display("FAIL cmd_ready_wait got=%0b want=1", cmd_ready);
        else passes++;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        int n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = rsp_valid;
    endtask

    task automatic test_reset();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'h0})
            $display("FAIL reset_rsp got=%0b%0b%0b %0h %0h want=100 0 0",
                     cmd_ready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata);
        else passes++;
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0)
            $display("FAIL reset_axi got=%b want=00000",
                     {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
        else passes++;
        checks++;
        if ({axi.awaddr, axi.wdata, axi.wstrb, axi.awprot, axi.arprot} !== '0)
            $display("FAIL reset_regs got=%0h %0h %0h want=0", axi.awaddr, axi.wdata, axi.wstrb);
        else passes++;
    endtask

    task automatic test_write_basic(input logic [4:0] a, input logic [31:0] d,
                                    input logic [3:0] s);
        exp_t e;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        exp_q.push_back('{32'h0, 2'b00, 1'b0});
        issue(1'b1, a, d, s);
        checks++;
        if ({axi.awvalid, axi.wvalid, cmd_ready} !== 3'b110)
            $display("FAIL wr_n1_valid got=%b want=110", {axi.awvalid, axi.wvalid, cmd_ready});
        else passes++;
        checks++;
        if ({axi.awaddr, axi.wdata, axi.wstrb} !== {a, d, s})
            $display("FAIL wr_payload got=%0h %0h %0h want=%0h %0h %0h",
                     axi.awaddr, axi.wdata, axi.wstrb, a, d, s);
        else passes++;
        @(negedge clk);
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001)
            $display("FAIL wr_n2_bready got=%b want=001", {axi.awvalid, axi.wvalid, axi.bready});
        else passes++;
        @(negedge clk);
        checks++;
        if ({axi.bready, rsp_valid} !== 2'b10)
            $display("FAIL wr_n3 got=%b want=10", {axi.bready, rsp_valid});
        else passes++;
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b00;
        @(negedge clk);
        axi.bvalid = 1'b0;
        checks++;
        if ({rsp_valid, axi.bready} !== 2'b10)
            $display("FAIL wr_n4_rsp got=%b want=10", {rsp_valid, axi.bready});
        else passes++;
        e = exp_q.pop_front();
        checks++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== {e.rdata, e.resp, e.to})
            $display("FAIL wr_rsp_payload got=%0h %0h %0b want=%0h %0h %0b",
                     rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        else passes++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL wr_done got=%b want=01", {rsp_valid, cmd_ready});
        else passes++;
    endtask

    task automatic test_write_wstall();
        exp_t e;
        bit   ok;
        axi.awready = 1'b1;
        axi.wready  = 1'b0;
        exp_q.push_back('{32'h0, 2'b01, 1'b0});
        issue(1'b1, 5'h10, 32'h0BAD_F00D, 4'hC);
        checks++;
        if ({axi.awvalid, axi.wvalid} !== 2'b11)
            $display("FAIL ws_start got=%b want=11", {axi.awvalid, axi.wvalid});
        else passes++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            axi.awready = 1'b0;
            checks++;
            if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b010)
                $display("FAIL ws_hold%0d got=%b want=010", i,
                         {axi.awvalid, axi.wvalid, axi.bready});
            else passes++;
        end
        axi.wready = 1'b1;
        @(negedge clk);
        axi.wready = 1'b0;
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001)
            $display("FAIL ws_both got=%b want=001", {axi.awvalid, axi.wvalid, axi.bready});
        else passes++;
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b01;
        @(negedge clk);
        axi.bvalid = 1'b0;
        wait_rsp(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rsp_rdata, rsp_resp, rsp_timeout} !== {e.rdata, e.resp, e.to})
            $display("FAIL ws_rsp got=%0b %0h %0h %0b want=1 %0h %0h %0b",
                     ok, rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        else passes++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready, axi.bready} !== 3'b010)
            $display("FAIL ws_single got=%b want=010", {rsp_valid, cmd_ready, axi.bready});
        else passes++;
    endtask

    task automatic test_read(input logic [4:0] a, input logic [31:0] rd,
                             input logic [1:0] rr, input int hold);
        exp_t e;
        axi.arready = 1'b1;
        exp_q.push_back('{rd, rr, 1'b0});
        issue(1'b0, a, 32'h0, 4'h0);
        checks++;
        if ({axi.arvalid, axi.araddr} !== {1'b1, a})
            $display("FAIL rd_ar got=%b %0h want=1 %0h", axi.arvalid, axi.araddr, a);
        else passes++;
        @(negedge clk);
        axi.arready = 1'b0;
        checks++;
        if ({axi.arvalid, axi.rready} !== 2'b01)
            $display("FAIL rd_rready got=%b want=01", {axi.arvalid, axi.rready});
        else passes++;
        repeat (2) @(negedge clk);
        axi.rvalid = 1'b1;
        axi.rdata  = rd;
        axi.rresp  = rr;
        @(negedge clk);
        axi.rvalid = 1'b0;
        axi.rdata  = 32'h0;
        axi.rresp  = 2'b00;
        checks++;
        if ({axi.rready, rsp_valid} !== 2'b01)
            $display("FAIL rd_rready_drop got=%b want=01", {axi.rready, rsp_valid});
        else passes++;
        e = exp_q.pop_front();
        checks++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== {e.rdata, e.resp, e.to})
            $display("FAIL rd_payload got=%0h %0h %0b want=%0h %0h %0b",
                     rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        else passes++;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_rdata, rsp_resp} !== {1'b1, e.rdata, e.resp} ||
                {axi.awvalid, axi.wvalid, axi.arvalid, axi.rready, axi.bready} !== 5'b0)
                $display("FAIL rd_hold%0d got=%b %0h %0h want=1 %0h %0h", i,
                         rsp_valid, rsp_rdata, rsp_resp, e.rdata, e.resp);
            else passes++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL rd_done got=%b want=01", {rsp_valid, cmd_ready});
        else passes++;
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n = 0;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        exp_q.push_back('{32'h0, 2'b00, 1'b1});
        issue(1'b1, 5'h14, 32'hCAFE_F00D, 4'h3);
        @(negedge clk);
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        while (axi.bready && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 8) $display("FAIL to_bready_cycles got=%0d want=8", n);
        else passes++;
        e = exp_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !== {1'b1, e.rdata, e.resp, e.to})
            $display("FAIL to_rsp got=%b %0h %0h %0b want=1 %0h %0h %0b",
                     rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        else passes++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, rsp_timeout, cmd_ready} !== 3'b001)
            $display("FAIL to_clear got=%b want=001", {rsp_valid, rsp_timeout, cmd_ready});
        else passes++;
        test_write_basic(5'h00, 32'h0000_0055, 4'h1);
    endtask

    task automatic test_reset_mid();
        axi.arready = 1'b0;
        issue(1'b0, 5'h0C, 32'h0, 4'h0);
        checks++;
        if (axi.arvalid !== 1'b1) $display("FAIL rst_pending got=%b want=1", axi.arvalid);
        else passes++;
        areset = 1'b1;
        @(negedge clk);
        checks++;
        if ({axi.arvalid, cmd_ready, rsp_valid} !== 3'b010)
            $display("FAIL rst_mid got=%b want=010", {axi.arvalid, cmd_ready, rsp_valid});
        else passes++;
        areset = 1'b0;
        @(negedge clk);
        test_read(5'h18, 32'h0F0F_A5A5, 2'b00, 0);
    endtask

    initial begin
        areset      = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        cmd_wstrb   = '0;
        rsp_ready   = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
        repeat (3) @(negedge clk);
        test_reset();
        areset = 1'b0;
        @(negedge clk);
        test_write_basic(5'h04, 32'hDEAD_BEEF, 4'hF);
        test_write_wstall();
        test_read(5'h08, 32'h1234_5678, 2'b00, 0);
        test_read(5'h1C, 32'hA5A5_0001, 2'b10, 4);
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
